// File: rtl/ansi_term_decoder.sv
// ansi_term_decoder: turns a text + ANSI CSI byte stream into positioned glyph events.
// Optional build macro ANSI_DEC_UTF8_EN: UTF-8 lead bytes render as glyph 0x7F.
module ansi_term_decoder #(
    parameter int ROWS = 24,
    parameter int COLS = 80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic       in_ready,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic [7:0] pix_row,
    output logic [7:0] pix_col,
    output logic [7:0] pix_char,
    output logic [2:0] pix_fg,
    output logic       pix_bold,
    output logic       clear_pulse,
    output logic       err_pulse,
    output logic [7:0] cur_row,
    output logic [7:0] cur_col
);

    localparam logic [7:0] LP_ROWS = 8'(ROWS);
    localparam logic [7:0] LP_COLS = 8'(COLS);
    localparam logic [7:0] C_ESC   = 8'h1B;
    localparam logic [7:0] C_CR    = 8'h0D;
    localparam logic [7:0] C_LF    = 8'h0A;
    localparam logic [7:0] C_LBR   = 8'h5B;
    localparam logic [7:0] C_SEMI  = 8'h3B;
    localparam logic [7:0] C_H     = 8'h48;
    localparam logic [7:0] C_J     = 8'h4A;
    localparam logic [7:0] C_M     = 8'h6D;

    typedef enum logic [1:0] {
        S_GROUND,
        S_ESC,
        S_CSI
    } state_t;

    state_t     r_state;
    state_t     w_next_state;

    logic [7:0] r_row;
    logic [7:0] r_col;
    logic [2:0] r_fg;
    logic       r_bold;
    logic [7:0] r_p0;
    logic [7:0] r_p1;
    logic       r_idx;
    logic       r_drop;

    logic       r_pix_valid;
    logic [7:0] r_pix_row;
    logic [7:0] r_pix_col;
    logic [7:0] r_pix_char;
    logic [2:0] r_pix_fg;
    logic       r_pix_bold;
    logic       r_clear;
    logic       r_err;

    logic       w_accept;
    logic       w_is_digit;
    logic       w_is_print;
    logic       w_is_final;
    logic       w_is_high;
`ifdef ANSI_DEC_UTF8_EN
    logic       w_is_lead;
`endif
    logic [7:0] w_row_inc;
    logic [7:0] w_col_inc;

    logic       w_emit;
    logic [7:0] w_emit_char;
    logic       w_err;
    logic       w_clear;
    logic [7:0] w_row_n;
    logic [7:0] w_col_n;
    logic [2:0] w_fg_n;
    logic       w_bold_n;
    logic [7:0] w_p0_n;
    logic [7:0] w_p1_n;
    logic       w_idx_n;
    logic       w_drop_n;
    logic [3:0] w_sgr;

    // Decimal accumulate with saturation at 255.
    function automatic logic [7:0] f_acc(input logic [7:0] p, input logic [3:0] d);
        logic [11:0] v;
        v = ({4'd0, p} * 12'd10) + {8'd0, d};
        return (v > 12'd255) ? 8'd255 : v[7:0];
    endfunction

    // Zero means "default" (1); anything beyond the screen edge pins to it.
    function automatic logic [7:0] f_clamp(input logic [7:0] p, input logic [7:0] lim);
        logic [7:0] v;
        v = p;
        if (p == 8'd0) v = 8'd1;
        else if (p > lim) v = lim;
        return v;
    endfunction

    // One SGR parameter applied to {bold, fg}; unknown codes leave it alone.
    function automatic logic [3:0] f_sgr(input logic [7:0] p, input logic [3:0] a);
        logic [3:0] v;
        v = a;
        if (p == 8'd0) v = 4'b0111;
        else if (p == 8'd1) v[3] = 1'b1;
        else if (p >= 8'd30 && p <= 8'd37) v[2:0] = 3'(p - 8'd30);
        return v;
    endfunction

    assign in_ready  = !r_pix_valid || pix_ready;
    assign w_accept  = in_valid && in_ready;

    assign w_is_digit = (in_byte >= 8'h30) && (in_byte <= 8'h39);
    assign w_is_print = (in_byte >= 8'h20) && (in_byte <= 8'h7E);
    assign w_is_final = (in_byte >= 8'h40) && (in_byte <= 8'h7E);
    assign w_is_high  = in_byte[7];
`ifdef ANSI_DEC_UTF8_EN
    assign w_is_lead  = (in_byte[7:6] == 2'b11);
`endif

    assign w_row_inc = (r_row < LP_ROWS) ? r_row + 8'd1 : r_row;
    assign w_col_inc = (r_col < LP_COLS) ? r_col + 8'd1 : r_col;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_GROUND;
        else     r_state <= w_next_state;
    end

    // FSM next-state logic; only an accepted byte moves the machine.
    always_comb begin
        w_next_state = r_state;
        if (w_accept) begin
            unique case (r_state)
                S_GROUND: begin
                    if (in_byte == C_ESC) w_next_state = S_ESC;
                end
                S_ESC: begin
                    if (in_byte == C_LBR)      w_next_state = S_CSI;
                    else if (in_byte != C_ESC) w_next_state = S_GROUND;
                end
                S_CSI: begin
                    if (in_byte == C_ESC)
                        w_next_state = S_ESC;
                    else if (!w_is_digit && in_byte != C_SEMI)
                        w_next_state = S_GROUND;
                end
                default: w_next_state = S_GROUND;
            endcase
        end
    end

    // FSM outputs: event/pulse requests and next cursor, attribute, param values.
    always_comb begin
        w_emit      = 1'b0;
        w_emit_char = in_byte;
        w_err       = 1'b0;
        w_clear     = 1'b0;
        w_row_n     = r_row;
        w_col_n     = r_col;
        w_fg_n      = r_fg;
        w_bold_n    = r_bold;
        w_p0_n      = r_p0;
        w_p1_n      = r_p1;
        w_idx_n     = r_idx;
        w_drop_n    = r_drop;
        w_sgr       = {r_bold, r_fg};
        if (w_accept) begin
            unique case (r_state)
                S_GROUND: begin
                    if (w_is_print) begin
                        w_emit  = 1'b1;
                        w_col_n = w_col_inc;
                    end else if (in_byte == C_CR) begin
                        w_col_n = 8'd1;
                    end else if (in_byte == C_LF) begin
                        w_row_n = w_row_inc;
                        w_col_n = 8'd1;
                    end else if (w_is_high) begin
`ifdef ANSI_DEC_UTF8_EN
                        if (w_is_lead) begin
                            w_emit      = 1'b1;
                            w_emit_char = 8'h7F;
                            w_col_n     = w_col_inc;
                        end
`else
                        w_err = 1'b1;
`endif
                    end
                end
                S_ESC: begin
                    if (in_byte == C_LBR) begin
                        w_p0_n   = 8'd0;
                        w_p1_n   = 8'd0;
                        w_idx_n  = 1'b0;
                        w_drop_n = 1'b0;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                S_CSI: begin
                    if (w_is_digit) begin
                        if (!r_idx)       w_p0_n = f_acc(r_p0, in_byte[3:0]);
                        else if (!r_drop) w_p1_n = f_acc(r_p1, in_byte[3:0]);
                    end else if (in_byte == C_SEMI) begin
                        if (!r_idx) w_idx_n  = 1'b1;
                        else        w_drop_n = 1'b1;
                    end else if (in_byte == C_ESC) begin
                        w_err = 1'b1;
                    end else if (in_byte == C_H) begin
                        w_row_n = f_clamp(r_p0, LP_ROWS);
                        w_col_n = f_clamp(r_p1, LP_COLS);
                    end else if (in_byte == C_J) begin
                        w_clear = (r_p0 == 8'd2);
                    end else if (in_byte == C_M) begin
                        w_sgr = f_sgr(r_p0, {r_bold, r_fg});
                        if (r_idx) w_sgr = f_sgr(r_p1, w_sgr);
                        w_bold_n = w_sgr[3];
                        w_fg_n   = w_sgr[2:0];
                    end else if (!w_is_final) begin
                        w_err = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Cursor, attributes and CSI parameter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row  <= 8'd1;
            r_col  <= 8'd1;
            r_fg   <= 3'd7;
            r_bold <= 1'b0;
            r_p0   <= 8'd0;
            r_p1   <= 8'd0;
            r_idx  <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            r_row  <= w_row_n;
            r_col  <= w_col_n;
            r_fg   <= w_fg_n;
            r_bold <= w_bold_n;
            r_p0   <= w_p0_n;
            r_p1   <= w_p1_n;
            r_idx  <= w_idx_n;
            r_drop <= w_drop_n;
        end
    end

    // Event slot: load on emit, hold until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_valid <= 1'b0;
            r_pix_row   <= 8'd1;
            r_pix_col   <= 8'd1;
            r_pix_char  <= 8'd0;
            r_pix_fg    <= 3'd7;
            r_pix_bold  <= 1'b0;
        end else if (w_emit) begin
            r_pix_valid <= 1'b1;
            r_pix_row   <= r_row;
            r_pix_col   <= r_col;
            r_pix_char  <= w_emit_char;
            r_pix_fg    <= r_fg;
            r_pix_bold  <= r_bold;
        end else if (pix_ready) begin
            r_pix_valid <= 1'b0;
        end
    end

    // One-cycle strobes for clear and malformed bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clear <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_clear <= w_clear;
            r_err   <= w_err;
        end
    end

    assign pix_valid   = r_pix_valid;
    assign pix_row     = r_pix_row;
    assign pix_col     = r_pix_col;
    assign pix_char    = r_pix_char;
    assign pix_fg      = r_pix_fg;
    assign pix_bold    = r_pix_bold;
    assign clear_pulse = r_clear;
    assign err_pulse   = r_err;
    assign cur_row     = r_row;
    assign cur_col     = r_col;

endmodule

// File: tb/tb_ansi_term_decoder.sv
// tb_ansi_term_decoder: table-driven byte vectors plus hand sequences for
// column saturation, backpressure and reset mid-sequence.
module tb_ansi_term_decoder;

    localparam logic [7:0] ESC = 8'h1B;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_ready;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] pix_row;
    logic [7:0] pix_col;
    logic [7:0] pix_char;
    logic [2:0] pix_fg;
    logic       pix_bold;
    logic       clear_pulse;
    logic       err_pulse;
    logic [7:0] cur_row;
    logic [7:0] cur_col;

    int checks;
    int failures;

    ansi_term_decoder #(.ROWS(24), .COLS(80)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_byte     (in_byte),
        .in_ready    (in_ready),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_row     (pix_row),
        .pix_col     (pix_col),
        .pix_char    (pix_char),
        .pix_fg      (pix_fg),
        .pix_bold    (pix_bold),
        .clear_pulse (clear_pulse),
        .err_pulse   (err_pulse),
        .cur_row     (cur_row),
        .cur_col     (cur_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] b;
        logic       ev;
        logic [7:0] prow;
        logic [7:0] pcol;
        logic [7:0] ch;
        logic [2:0] fg;
        logic       bo;
        logic       er;
        logic       cl;
        logic [7:0] crow;
        logic [7:0] ccol;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic [7:0] b, input logic ev,
                                input logic [7:0] pr, input logic [7:0] pc,
                                input logic [7:0] ch, input logic [2:0] fg,
                                input logic bo, input logic er, input logic cl,
                                input logic [7:0] r, input logic [7:0] c);
        vec_t v;
        v = '{b:b, ev:ev, prow:pr, pcol:pc, ch:ch, fg:fg, bo:bo,
              er:er, cl:cl, crow:r, ccol:c};
        vq.push_back(v);
    endfunction

    function automatic void v_n(input logic [7:0] b, input logic [7:0] r, input logic [7:0] c);
        add(b, 1'b0, 8'd1, 8'd1, 8'd0, 3'd7, 1'b0, 1'b0, 1'b0, r, c);
    endfunction

    function automatic void v_x(input logic [7:0] b, input logic [7:0] r, input logic [7:0] c);
        add(b, 1'b0, 8'd1, 8'd1, 8'd0, 3'd7, 1'b0, 1'b1, 1'b0, r, c);
    endfunction

    function automatic void v_c(input logic [7:0] b, input logic [7:0] r, input logic [7:0] c);
        add(b, 1'b0, 8'd1, 8'd1, 8'd0, 3'd7, 1'b0, 1'b0, 1'b1, r, c);
    endfunction

    function automatic void v_e(input logic [7:0] b, input logic [7:0] pr, input logic [7:0] pc,
                                input logic [7:0] ch, input logic [2:0] fg, input logic bo,
                                input logic [7:0] r, input logic [7:0] c);
        add(b, 1'b1, pr, pc, ch, fg, bo, 1'b0, 1'b0, r, c);
    endfunction

    function automatic void v_s(input string s, input logic [7:0] r, input logic [7:0] c);
        for (int i = 0; i < s.len(); i++) v_n(s[i], r, c);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    logic [7:0] abc[3];
    logic [7:0] got[$];
    int         bi;
    logic       acc;
    logic       tk;
    logic [7:0] ch;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        pix_ready = 1'b1;
        abc[0] = "A";
        abc[1] = "B";
        abc[2] = "C";

        v_n(ESC, 1, 1);  v_s("[5;10", 1, 1);  v_n("H", 5, 10);
        v_e("A", 5, 10, 8'h41, 7, 0, 5, 11);
        v_n(ESC, 5, 11); v_s("[1;32", 5, 11); v_n("m", 5, 11);
        v_e("=", 5, 11, 8'h3D, 2, 1, 5, 12);
        v_n(ESC, 5, 12); v_s("[0", 5, 12);    v_n("m", 5, 12);
        v_e("=", 5, 12, 8'h3D, 7, 0, 5, 13);
        v_n(ESC, 5, 13); v_s("[2", 5, 13);    v_c("J", 5, 13);
        v_n(ESC, 5, 13); v_s("[3", 5, 13);    v_n("J", 5, 13);
        v_n(ESC, 5, 13); v_s("[300;999", 5, 13); v_n("H", 24, 80);
        v_e("y", 24, 80, 8'h79, 7, 0, 24, 80);
        v_n(8'h0A, 24, 1);
        v_n(ESC, 24, 1); v_s("[0;0", 24, 1);  v_n("H", 1, 1);
        v_e("B", 1, 1, 8'h42, 7, 0, 1, 2);
        v_n(8'h0D, 1, 1);
        v_n(8'h0A, 2, 1);
        v_n(8'h07, 2, 1);
        v_n(ESC, 2, 1);  v_x("x", 2, 1);
        v_e("Z", 2, 1, 8'h5A, 7, 0, 2, 2);
        v_n(ESC, 2, 2);  v_x(ESC, 2, 2);      v_n("[", 2, 2); v_n("H", 1, 1);
        v_n(ESC, 1, 1);  v_s("[5", 1, 1);     v_x(ESC, 1, 1);
        v_s("[2;2", 1, 1); v_n("H", 2, 2);
        v_n(ESC, 2, 2);  v_n("[", 2, 2);      v_x("!", 2, 2);
        v_e("k", 2, 2, 8'h6B, 7, 0, 2, 3);
        v_n(ESC, 2, 3);  v_s("[7", 2, 3);     v_n("K", 2, 3);
        v_e("k", 2, 3, 8'h6B, 7, 0, 2, 4);
        v_n(ESC, 2, 4);  v_s("[1;31", 2, 4);  v_n("m", 2, 4);
        v_n(ESC, 2, 4);  v_s("[99", 2, 4);    v_n("m", 2, 4);
        v_e("q", 2, 4, 8'h71, 1, 1, 2, 5);
        v_n(ESC, 2, 5);  v_s("[;5", 2, 5);    v_n("H", 1, 5);
        v_n(ESC, 1, 5);  v_s("[4;5;6", 1, 5); v_n("H", 4, 5);
        v_n(ESC, 4, 5);  v_s("[0", 4, 5);     v_n("m", 4, 5);
`ifdef ANSI_DEC_UTF8_EN
        v_e(8'hE2, 4, 5, 8'h7F, 7, 0, 4, 6);
        v_n(8'h96, 4, 6);
        v_n(8'h88, 4, 6);
        v_e("u", 4, 6, 8'h75, 7, 0, 4, 7);
`else
        v_x(8'hE2, 4, 5);
        v_x(8'h96, 4, 5);
        v_x(8'h88, 4, 5);
        v_e("u", 4, 5, 8'h75, 7, 0, 4, 6);
`endif

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_payload", {pix_row, pix_col, pix_char, pix_fg, pix_bold},
            {8'd1, 8'd1, 8'd0, 3'd7, 1'b0});
        chk("rst_pulses", {clear_pulse, err_pulse}, 32'd0);
        chk("rst_cursor", {cur_row, cur_col}, {8'd1, 8'd1});
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < vq.size(); i++) begin
            send(vq[i].b);
            chk($sformatf("v%0d_ev", i), 32'(pix_valid), 32'(vq[i].ev));
            if (vq[i].ev)
                chk($sformatf("v%0d_payload", i),
                    {pix_row, pix_col, pix_char, pix_fg, pix_bold},
                    {vq[i].prow, vq[i].pcol, vq[i].ch, vq[i].fg, vq[i].bo});
            chk($sformatf("v%0d_err", i), 32'(err_pulse), 32'(vq[i].er));
            chk($sformatf("v%0d_clr", i), 32'(clear_pulse), 32'(vq[i].cl));
            chk($sformatf("v%0d_cur", i), {cur_row, cur_col}, {vq[i].crow, vq[i].ccol});
        end

        send(ESC);
        send_str("[1;1H");
        for (int i = 0; i < 82; i++) begin
            send("x");
            chk($sformatf("sat%0d_pos", i), {pix_valid, pix_row, pix_col},
                {1'b1, 8'd1, (i + 1 > 80) ? 8'd80 : 8'(i + 1)});
        end
        chk("sat_cur", {cur_row, cur_col}, {8'd1, 8'd80});

        send(ESC);
        send_str("[3;3H");
        bi = 0;
        got.delete();
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            pix_ready = (cyc >= 5);
            in_valid  = (bi < 3);
            if (bi < 3) in_byte = abc[bi];
            #1;
            if (cyc == 3) begin
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                chk("bp_held", {pix_valid, pix_char}, {1'b1, 8'h41});
                chk("bp_accepted", 32'(bi), 32'd1);
                chk("bp_cur", 32'(cur_col), 32'd4);
            end
            acc = in_valid && in_ready;
            tk  = pix_valid && pix_ready;
            ch  = pix_char;
            @(posedge clk);
            if (tk) got.push_back(ch);
            if (acc) bi++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        pix_ready = 1'b1;
        chk("bp_count", 32'(got.size()), 32'd3);
        for (int k = 0; k < 3; k++)
            if (k < got.size())
                chk($sformatf("bp_ev%0d", k), 32'(got[k]), 32'(abc[k]));
        chk("bp_cur_end", {cur_row, cur_col}, {8'd3, 8'd6});

        send(ESC);
        send_str("[5");
        pix_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_cur", {cur_row, cur_col}, {8'd1, 8'd1});
        @(negedge clk);
        rst = 1'b0;
        send("H");
        chk("mid_rst_ground", {pix_valid, pix_row, pix_col, pix_char},
            {1'b1, 8'd1, 8'd1, 8'h48});
        chk("mid_rst_cur2", {cur_row, cur_col}, {8'd1, 8'd2});
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_drops_event", {pix_valid, pix_char}, {1'b0, 8'h00});
        @(negedge clk);
        rst = 1'b0;
        pix_ready = 1'b1;

        send(ESC);
        send_str("[2J");
        chk("clr_hi", 32'(clear_pulse), 32'd1);
        @(posedge clk);
        #1;
        chk("clr_one_cycle", 32'(clear_pulse), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
